// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder step per clock, LSB first.
// Operands are captured on the accepting edge and the result is published on DONE.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic             SUB,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             COUT,
  output logic             OVF
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;
  logic [1:0]       fa;

  // Returns {carry_out, sum} of a single-bit full adder.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign fa       = full_add(a_reg[0], b_reg[0], carry);
  assign BUSY     = (state == ST_SHIFT);
  assign DONE     = (state == ST_DONE);

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (START) state_nx = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // a_reg doubles as the result register: each sum bit enters at the MSB
  // as the consumed operand bit leaves at the LSB.
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      COUT  <= 1'b0;
      OVF   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            a_reg <= A;
            b_reg <= SUB ? ~B : B;
            carry <= CIN ^ SUB;
            cnt   <= '0;
          end
        end
        ST_SHIFT: begin
          a_reg <= {fa[0], a_reg[WIDTH-1:1]};
          b_reg <= {1'b0, b_reg[WIDTH-1:1]};
          carry <= fa[1];
          cnt   <= cnt + CNT_W'(1);
          if (last_bit) begin
            S    <= {fa[0], a_reg[WIDTH-1:1]};
            COUT <= fa[1];
            OVF  <= carry ^ fa[1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed and random 8-bit operations plus an
// exhaustive 2-bit sweep with START held high, against an arithmetic model.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       st8, cin8, sub8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, s8;
  logic       st2, cin2, sub2, busy2, done2, cout2, ovf2;
  logic [1:0] a2, b2, s2;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder #(.WIDTH(8)) u8 (
    .CLK(clk), .RST(rst), .START(st8), .A(a8), .B(b8), .CIN(cin8), .SUB(sub8),
    .BUSY(busy8), .DONE(done8), .S(s8), .COUT(cout8), .OVF(ovf8)
  );

  serial_adder #(.WIDTH(2)) u2 (
    .CLK(clk), .RST(rst), .START(st2), .A(a2), .B(b2), .CIN(cin2), .SUB(sub2),
    .BUSY(busy2), .DONE(done2), .S(s2), .COUT(cout2), .OVF(ovf2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Signed/unsigned arithmetic view of the operation, independent of any bit-serial detail.
  function automatic void ref_model(input int w, input longint a, input longint b,
                                    input bit cin, input bit sub,
                                    output logic [31:0] s, output logic cout, output logic ovf);
    longint m, sa, sb, r, sr;
    m  = longint'(1) << w;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    if (!sub) begin
      r    = a + b + cin;
      cout = (r >= m);
      sr   = sa + sb + cin;
    end else begin
      r    = a - b - cin;
      cout = (a >= b + cin);
      sr   = sa - sb - cin;
    end
    s   = 32'(((r % m) + m) % m);
    ovf = (sr >= m / 2) || (sr < -(m / 2));
  endfunction

  // One 8-bit operation; inputs are scrambled right after acceptance, and
  // with poke set a second START with other operands is pulsed mid-operation.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input bit cin, input bit sub, input bit poke);
    logic [31:0] es;
    logic        ec, eo;
    logic [7:0]  prev_s;
    int          j, busy_n;
    bit          stable;
    ref_model(8, a, b, cin, sub, es, ec, eo);
    @(negedge clk);
    st8 = 1'b1; a8 = a; b8 = b; cin8 = cin; sub8 = sub;
    @(negedge clk);
    st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
    prev_s = s8; j = 0; busy_n = 0; stable = 1'b1;
    while (!done8 && j < 40) begin
      busy_n += int'(busy8);
      if (s8 !== prev_s) stable = 1'b0;
      if (poke && j == 3) begin
        st8 = 1'b1; a8 = ~a; b8 = b ^ 8'h5A; cin8 = ~cin; sub8 = ~sub;
      end
      if (poke && j == 4) st8 = 1'b0;
      @(negedge clk);
      j++;
    end
    check({tag, "_latency"}, j, 8);
    check({tag, "_busy_cycles"}, busy_n, 8);
    check({tag, "_s_stable"}, stable, 1);
    check({tag, "_done"}, done8, 1'b1);
    check({tag, "_s"}, s8, es);
    check({tag, "_cout"}, cout8, ec);
    check({tag, "_ovf"}, ovf8, eo);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done8, 1'b0);
  endtask

  initial begin
    int          t, busy_n;
    bit          saw_done;
    int unsigned last_done;
    logic [31:0] es;
    logic        ec, eo;
    logic [5:0]  v;

    rst = 1'b1;
    st8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    st2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; sub2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy8, 1'b0);
    check("rst_done", done8, 1'b0);
    check("rst_s", s8, 8'h00);
    check("rst_cout", cout8, 1'b0);
    check("rst_ovf", ovf8, 1'b0);
    check("rst_busy2", busy2, 1'b0);
    rst = 1'b0;

    run8("add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);
    run8("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    run8("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    run8("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 1'b0);
    run8("add_cin", 8'hA5, 8'h3C, 1'b1, 1'b0, 1'b0);
    run8("sub_borrow", 8'h40, 8'h10, 1'b1, 1'b1, 1'b0);
    run8("start_ignored", 8'h21, 8'h13, 1'b0, 1'b0, 1'b1);
    run8("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 1'b0);

    // Reset during the 4th shift cycle aborts the operation without a DONE.
    @(negedge clk);
    st8 = 1'b1; a8 = 8'h33; b8 = 8'h44; cin8 = 1'b0; sub8 = 1'b0;
    @(negedge clk);
    st8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy8, 1'b0);
    check("abort_done", done8, 1'b0);
    check("abort_s", s8, 8'h00);
    check("abort_cout", cout8, 1'b0);
    check("abort_ovf", ovf8, 1'b0);
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 1'b0);
    run8("after_abort", 8'h9C, 8'h27, 1'b0, 1'b1, 1'b0);

    // START on the same edge as RST is dropped; accepted on the first free edge.
    @(negedge clk);
    rst = 1'b1; st8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; sub8 = 1'b0;
    @(negedge clk);
    check("rst_start_ignored", busy8, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_start_accept", busy8, 1'b1);
    st8 = 1'b0;
    t = 0; busy_n = 0;
    while (!done8 && t < 40) begin
      busy_n += int'(busy8);
      @(negedge clk);
      t++;
    end
    check("rst_start_busy_cycles", busy_n, 8);
    check("rst_start_s", s8, 8'h47);
    @(negedge clk);

    for (int k = 0; k < 24; k++) begin
      run8("rand", 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    // WIDTH=2 exhaustive sweep, START held high throughout.
    last_done = 0;
    @(negedge clk);
    v = 6'd0;
    {a2, b2, cin2, sub2} = v;
    st2 = 1'b1;
    for (int n = 0; n < 64; n++) begin
      v = 6'(n);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!busy2 && t < 10);
      check("w2_accept", busy2, 1'b1);
      ref_model(2, v[5:4], v[3:2], v[1], v[0], es, ec, eo);
      if (n < 63) begin
        v = 6'(n + 1);
        {a2, b2, cin2, sub2} = v;
      end else begin
        st2 = 1'b0;
      end
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!done2 && t < 10);
      check("w2_done", done2, 1'b1);
      check("w2_s", s2, es);
      check("w2_cout", cout2, ec);
      check("w2_ovf", ovf2, eo);
      if (n > 0) check("w2_spacing", cyc - last_done, 4);
      last_done = cyc;
    end
    @(negedge clk);
    check("w2_idle_end", busy2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
